// File: rtl/inventory_arbiter.sv
// Three-port round-robin arbiter serialising dispense / restock / query
// operations onto a single-port inventory RAM with 1-cycle synchronous read.
module inventory_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_ITEMS = 16,
  parameter int unsigned MAX_STOCK = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]     req_amount,
  output logic [2:0]            req_grant,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_we,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0]      PORT_DISP = 2'd0;
  localparam logic [1:0]      PORT_RSTK = 2'd1;
  localparam logic [DATA_W:0] MAX_SUM   = (DATA_W+1)'(MAX_STOCK);

  state_t              state, state_nxt;
  logic [1:0]          ptr;
  logic [1:0]          lat_port;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_amount;
  logic [DATA_W-1:0]   stock;

  logic                sel_found;
  logic [1:0]          sel_port;
  logic [2:0]          cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oor;
  logic                grant_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   res_c;
  logic                err_c;
  logic [1:0]          rsp_port_c;

  // Round-robin pick: first requesting port starting at the priority pointer
  always_comb begin
    sel_found = 1'b0;
    sel_port  = ptr;
    cand      = '0;
    for (int i = 0; i < 3; i++) begin
      cand = 3'(ptr) + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!sel_found && req_valid[cand[1:0]]) begin
        sel_found = 1'b1;
        sel_port  = cand[1:0];
      end
    end
  end

  always_comb begin
    case (sel_port)
      2'd1:    sel_addr = req_addr[ADDR_W +: ADDR_W];
      2'd2:    sel_addr = req_addr[2*ADDR_W +: ADDR_W];
      default: sel_addr = req_addr[0 +: ADDR_W];
    endcase
    sel_oor = (32'(sel_addr) >= NUM_ITEMS);
  end

  assign sum_c = {1'b0, stock} + {1'b0, lat_amount};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the same-cycle grant and memory strobes
  always_comb begin
    state_nxt  = state;
    req_grant  = '0;
    grant_c    = 1'b0;
    mem_addr   = lat_addr;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    res_c      = '0;
    err_c      = 1'b0;
    rsp_port_c = lat_port;
    case (state)
      IDLE: begin
        if (rst_n && sel_found) begin
          grant_c    = 1'b1;
          req_grant  = 3'b001 << sel_port;
          rsp_port_c = sel_port;
          if (sel_oor) begin
            err_c     = 1'b1;
            state_nxt = RESP;
          end else begin
            mem_addr  = sel_addr;
            state_nxt = READ;
          end
        end
      end
      READ: state_nxt = EXEC;
      EXEC: begin
        state_nxt = RESP;
        if (lat_port == PORT_DISP) begin
          if (stock == '0) begin
            err_c = 1'b1;
          end else begin
            mem_we    = rst_n;
            mem_wdata = stock - DATA_W'(1);
            res_c     = stock - DATA_W'(1);
          end
        end else if (lat_port == PORT_RSTK) begin
          if (sum_c > MAX_SUM) begin
            err_c = 1'b1;
            res_c = stock;
          end else begin
            mem_we    = rst_n;
            mem_wdata = sum_c[DATA_W-1:0];
            res_c     = sum_c[DATA_W-1:0];
          end
        end else begin
          res_c = stock;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, priority pointer, stock capture and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= 2'd0;
      lat_port   <= 2'd0;
      lat_addr   <= '0;
      lat_amount <= '0;
      stock      <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      rsp_valid <= '0;
      if (grant_c) begin
        lat_port   <= sel_port;
        lat_addr   <= sel_addr;
        lat_amount <= req_amount;
        ptr        <= (sel_port == 2'd2) ? 2'd0 : sel_port + 2'd1;
      end
      if (state == READ) stock <= mem_rdata;
      if (state_nxt == RESP) begin
        rsp_valid <= 3'b001 << rsp_port_c;
        rsp_data  <= res_c;
        rsp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_inventory_arbiter.sv
// Self-checking bench for inventory_arbiter: directed vectors, round-robin,
// mid-operation reset and randomized single-port traffic against a stock model.
module tb_inventory_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int NUM_ITEMS = 16;
  localparam int MAX_STOCK = 255;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]   req_amount;
  logic [2:0]          req_grant;
  logic [2:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_we;
  logic                busy;

  logic                pre_en = 1'b0;
  logic [ADDR_W-1:0]   pre_addr;
  logic [DATA_W-1:0]   pre_data;
  logic [DATA_W-1:0]   ram [256];

  int n_tests = 0;
  int n_fail  = 0;
  int shadow [NUM_ITEMS];

  typedef struct {
    int port;
    int addr;
    int amt;
    int pre;
    int exp_data;
    bit exp_err;
  } vec_t;
  vec_t vecs [8];

  inventory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ITEMS(NUM_ITEMS), .MAX_STOCK(MAX_STOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_amount(req_amount),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Inventory RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input int v);
    pre_en   = 1'b1;
    pre_addr = ADDR_W'(a);
    pre_data = DATA_W'(v);
    tick();
    pre_en = 1'b0;
    if (a < NUM_ITEMS) shadow[a] = v;
  endtask

  // Stock rules applied to the shadow inventory
  function automatic void model_op(input int p, input int a, input int amt,
                                   output int data, output bit err, output bit we);
    int s;
    data = 0; err = 1'b0; we = 1'b0;
    if (a >= NUM_ITEMS) begin
      err = 1'b1;
      return;
    end
    s = shadow[a];
    if (p == 0) begin
      if (s == 0) err = 1'b1;
      else begin data = s - 1; we = 1'b1; end
    end else if (p == 1) begin
      if (s + amt > MAX_STOCK) begin err = 1'b1; data = s; end
      else begin data = s + amt; we = 1'b1; end
    end else begin
      data = s;
    end
    if (we) shadow[a] = data;
  endfunction

  // One request on one port, from the IDLE cycle through the response pulse
  task automatic do_op(input int p, input int a, input int amt,
                       output int got_data, output bit got_err);
    int exp_data; bit exp_err; bit exp_we; int lat;
    model_op(p, a, amt, exp_data, exp_err, exp_we);
    lat = (a >= NUM_ITEMS) ? 1 : 3;
    tick();
    req_addr = '0;
    req_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    req_amount = DATA_W'(amt);
    req_valid  = 3'b001 << p;
    #1;
    check("grant", 32'(req_grant), 32'(3'b001 << p));
    for (int k = 1; k <= lat; k++) begin
      tick();
      req_valid = '0;
      #1;
      if (k == 2) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
          check("mem_wdata", 32'(mem_wdata), exp_data);
          check("mem_addr", 32'(mem_addr), a);
        end
      end else begin
        check("mem_we_quiet", 32'(mem_we), 0);
      end
      check("busy", 32'(busy), 1);
      if (k < lat) check("rsp_early", 32'(rsp_valid), 0);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(3'b001 << p));
    check("rsp_data", 32'(rsp_data), exp_data);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    if (a < NUM_ITEMS) check("ram", 32'(ram[a]), shadow[a]);
    got_data = int'(rsp_data);
    got_err  = rsp_err;
  endtask

  initial begin
    int got_d; bit got_e; int d; bit e; bit w; int pexp;
    vecs[0] = '{port:0, addr:3,  amt:0,   pre:5,   exp_data:4,   exp_err:1'b0};
    vecs[1] = '{port:0, addr:7,  amt:0,   pre:0,   exp_data:0,   exp_err:1'b1};
    vecs[2] = '{port:1, addr:2,  amt:10,  pre:250, exp_data:250, exp_err:1'b1};
    vecs[3] = '{port:1, addr:2,  amt:5,   pre:-1,  exp_data:255, exp_err:1'b0};
    vecs[4] = '{port:2, addr:20, amt:0,   pre:-1,  exp_data:0,   exp_err:1'b1};
    vecs[5] = '{port:2, addr:5,  amt:0,   pre:42,  exp_data:42,  exp_err:1'b0};
    vecs[6] = '{port:1, addr:15, amt:255, pre:0,   exp_data:255, exp_err:1'b0};
    vecs[7] = '{port:0, addr:16, amt:0,   pre:-1,  exp_data:0,   exp_err:1'b1};

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_amount = '0;
    pre_addr = '0; pre_data = '0;
    tick();
    for (int a = 0; a < NUM_ITEMS; a++) preload(a, int'($urandom_range(1, 200)));

    // Reset state with all requests already raised
    req_valid  = 3'b111;
    req_addr   = {8'd12, 8'd11, 8'd10};
    req_amount = 16'd3;
    #1;
    check("rst_grant", 32'(req_grant), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);

    // Continuous requests on all ports: grants rotate every 4 cycles
    rst_n = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      #1;
      pexp = (c / 4) % 3;
      if (c % 4 == 0) begin
        check("rr_grant", 32'(req_grant), 32'(3'b001 << pexp));
        model_op(pexp, 10 + pexp, 3, d, e, w);
      end else begin
        check("rr_gap", 32'(req_grant), 0);
      end
    end
    tick(); req_valid = '0;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre >= 0) preload(vecs[i].addr, vecs[i].pre);
      do_op(vecs[i].port, vecs[i].addr, vecs[i].amt, got_d, got_e);
      check("tbl_data", got_d, vecs[i].exp_data);
      check("tbl_err", 32'(got_e), 32'(vecs[i].exp_err));
    end

    // Reset asserted while a dispense is in EXEC
    preload(9, 7);
    tick();
    req_addr = '0; req_addr[0 +: ADDR_W] = 8'd9; req_valid = 3'b001;
    #1;
    check("abort_grant", 32'(req_grant), 1);
    tick(); req_valid = '0;
    tick(); #1;
    check("abort_we_exec", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we_gated", 32'(mem_we), 0);
    tick(); #1;
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
    check("abort_rsp_data", 32'(rsp_data), 0);
    check("abort_rsp_err", 32'(rsp_err), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("abort_quiet", 32'({rsp_valid, mem_we, busy}), 0);
    end
    check("abort_ram", 32'(ram[9]), 7);

    // Randomized single-port traffic
    for (int i = 0; i < 150; i++) begin
      int gap;
      do_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 19)),
            int'($urandom_range(0, 60)), got_d, got_e);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end

    for (int a = 0; a < NUM_ITEMS; a++) check("final_ram", 32'(ram[a]), shadow[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inventory_arbiter.md
INVENTORY_ARBITER -- requirements
Module: inventory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning inventory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning stock word width.
REQ-003 SHALL have parameter NUM_ITEMS, default 16, meaning valid item addresses 0..NUM_ITEMS-1.
REQ-004 SHALL have parameter MAX_STOCK, default 255, meaning the restock ceiling.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 3 bits: request per port; port0 = dispense-decrement, port1 = restock-add, port2 = query-read.
REQ-008 SHALL have port req_addr, input, 3*ADDR_W bits: item address per port; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_amount, input, DATA_W bits: restock quantity, used by port1 only.
REQ-010 SHALL have port req_grant, output, 3 bits: one-hot, one-cycle acceptance pulse.
REQ-011 SHALL have port rsp_valid, output, 3 bits: one-hot, one-cycle completion pulse to the granted port.
REQ-012 SHALL have port rsp_data, output, DATA_W bits: result stock value, valid with rsp_valid.
REQ-013 SHALL have port rsp_err, output, 1 bit: operation rejected, valid with rsp_valid.
REQ-014 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W) and mem_we (output, 1): inventory RAM with 1-cycle synchronous read.
REQ-015 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, READ, EXEC and RESP, encoded in 2 bits.
REQ-017 In IDLE with any req_valid set, SHALL grant exactly one port using round-robin, pulse req_grant for that port in the same cycle, latch its port/addr/amount, drive mem_addr = latched addr, and go to READ.
REQ-018 Round-robin: the priority pointer resets to port0; after a grant to port k, the highest-priority port becomes (k+1) mod 3.
REQ-019 Requesters SHALL hold req_valid, req_addr and req_amount stable until granted; the block SHALL grant only in IDLE and SHALL not track a request dropped before its grant.
REQ-020 If the latched addr >= NUM_ITEMS, SHALL skip READ and EXEC, go directly to RESP with rsp_err=1 and rsp_data=0, and perform no memory write.
REQ-021 READ: SHALL capture mem_rdata into the stock register at the end of the cycle, then go to EXEC.
REQ-022 EXEC, decrement: if stock==0, SHALL set err=1 and result=0 with no write; otherwise SHALL set mem_we=1, mem_wdata=stock-1 and result=stock-1.
REQ-023 EXEC, restock: SHALL compute the sum at DATA_W+1 bits; if the sum exceeds MAX_STOCK, SHALL set err=1 and result=stock with no write; otherwise SHALL set mem_we=1, mem_wdata=sum and result=sum.
REQ-024 EXEC, query: SHALL set result=stock and err=0 with no write.
REQ-025 mem_we SHALL be high for exactly one cycle (EXEC) per successful write, with mem_addr held at the latched address.
REQ-026 RESP: SHALL pulse rsp_valid for the latched port for one cycle, with rsp_data and rsp_err registered, then go to IDLE.
REQ-027 Latency: grant in cycle N, mem_we in N+2, rsp_valid in N+3, next grant possible in N+4; range errors give rsp_valid in N+1.
REQ-028 Simultaneous requests on all ports SHALL be served in rotation with no starvation; each port is granted within 3 arbitration rounds.
REQ-029 rsp_data and rsp_err SHALL hold their last values outside rsp_valid.

Reset
REQ-030 On a clock edge with rst_n=0, SHALL force state=IDLE, priority pointer=port0, and req_grant, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_we and busy all to 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation: no write after the reset edge, and no rsp_valid for the aborted request.

Verification
REQ-032 Dispense, addr 3, RAM[3]=5 -> grant[0] at N, mem_we at N+2 with wdata=4, rsp_valid[0] at N+3 with data=4, err=0.
REQ-033 Dispense, addr 7, RAM[7]=0 -> rsp_err=1, rsp_data=0, mem_we never asserted, RAM[7] stays 0.
REQ-034 Restock, addr 2, RAM[2]=250, amount=10 -> rsp_err=1, rsp_data=250, no write; with amount=5 -> write 255, rsp_data=255.
REQ-035 All three req_valid held high continuously from reset -> grants in order port0, port1, port2, port0, spaced 4 cycles apart.
REQ-036 Query, addr 20 (NUM_ITEMS=16) -> rsp_valid[2] one cycle after grant, rsp_err=1, rsp_data=0, no memory access.
REQ-037 rst_n pulled low during EXEC of a dispense -> no mem_we after the reset edge, no rsp_valid, busy=0 and all outputs 0.
